// File: rtl/bsg_manycore_perf_counter_bank.sv
// Per-tile performance counter bank: saturating event and cycle counters run
// between start_i and finish_i, then are drained one word per ready handshake.
module bsg_manycore_perf_counter_bank #(
  parameter int  num_events_p    = 7,
  parameter int  counter_width_p = 32,
  parameter int  x_cord_width_p  = 2,
  parameter int  y_cord_width_p  = 3,
  localparam int idx_width_lp    = ($clog2(num_events_p + 1) < 1) ? 1 : $clog2(num_events_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic                       finish_i,
  input  logic [num_events_p-1:0]    events_i,
  input  logic [x_cord_width_p-1:0]  x_id_i,
  input  logic [y_cord_width_p-1:0]  y_id_i,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [idx_width_lp-1:0]    idx_o,
  output logic [counter_width_p-1:0] data_o,
  output logic [x_cord_width_p-1:0]  x_o,
  output logic [y_cord_width_p-1:0]  y_o,
  output logic                       overflow_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [counter_width_p-1:0] cnt_max_lp      = '1;
  localparam logic [counter_width_p-1:0] cnt_near_max_lp = cnt_max_lp - counter_width_p'(1);
  localparam logic [idx_width_lp-1:0]    last_idx_lp     = idx_width_lp'(num_events_p);

  state_e                      state_r;
  logic [counter_width_p-1:0]  cnt_r [num_events_p+1];
  logic [idx_width_lp-1:0]     ptr_r;
  logic [idx_width_lp-1:0]     idx_r;
  logic [counter_width_p-1:0]  data_r;
  logic [x_cord_width_p-1:0]   x_r;
  logic [y_cord_width_p-1:0]   y_r;
  logic                        v_r;
  logic                        done_r;
  logic                        overflow_r;

  logic [num_events_p:0]       hit_s;
  logic                        count_en_s;
  logic                        reach_s;
  logic [idx_width_lp-1:0]     nxt_ptr_s;
  logic [counter_width_p-1:0]  nxt_data_s;

  // Increment qualification, saturation detect and next readout word
  always_comb begin
    // Top slot is the cycle counter, which counts on every qualified cycle.
    hit_s      = {1'b1, events_i};
    count_en_s = (state_r == S_COUNT) && !start_i && !finish_i;
    reach_s    = 1'b0;
    for (int k = 0; k <= num_events_p; k++) begin
      reach_s = reach_s | (count_en_s & hit_s[k] & (cnt_r[k] == cnt_near_max_lp));
    end
    nxt_ptr_s = ptr_r + idx_width_lp'(1);
    if (ptr_r == last_idx_lp) begin
      nxt_data_s = '0;
    end else begin
      nxt_data_s = cnt_r[nxt_ptr_s];
    end
  end

  // Run-control FSM, counters and registered readout port
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= S_IDLE;
      ptr_r      <= '0;
      idx_r      <= '0;
      data_r     <= '0;
      x_r        <= '0;
      y_r        <= '0;
      v_r        <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      for (int k = 0; k <= num_events_p; k++) cnt_r[k] <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            for (int k = 0; k <= num_events_p; k++) cnt_r[k] <= '0;
            overflow_r <= 1'b0;
            x_r        <= x_id_i;
            y_r        <= y_id_i;
            done_r     <= 1'b0;
            state_r    <= S_COUNT;
          end
        end
        S_COUNT: begin
          // start_i takes priority over a coincident finish_i.
          if (start_i) begin
            for (int k = 0; k <= num_events_p; k++) cnt_r[k] <= '0;
            overflow_r <= 1'b0;
            x_r        <= x_id_i;
            y_r        <= y_id_i;
          end else if (finish_i) begin
            ptr_r   <= '0;
            idx_r   <= '0;
            data_r  <= cnt_r[0];
            v_r     <= 1'b1;
            state_r <= S_DRAIN;
          end else begin
            for (int k = 0; k <= num_events_p; k++) begin
              if (hit_s[k] && (cnt_r[k] != cnt_max_lp)) begin
                cnt_r[k] <= cnt_r[k] + counter_width_p'(1);
              end
            end
            overflow_r <= overflow_r | reach_s;
          end
        end
        S_DRAIN: begin
          if (ready_i) begin
            if (ptr_r == last_idx_lp) begin
              v_r     <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              ptr_r  <= nxt_ptr_s;
              idx_r  <= nxt_ptr_s;
              data_r <= nxt_data_s;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign v_o        = v_r;
  assign idx_o      = idx_r;
  assign data_o     = data_r;
  assign x_o        = x_r;
  assign y_o        = y_r;
  assign overflow_o = overflow_r;
  assign done_o     = done_r;

endmodule

// File: doc/bsg_manycore_perf_counter_bank.md
BSG_MANYCORE_PERF_COUNTER_BANK -- requirements
Module: bsg_manycore_perf_counter_bank

Interface
REQ-001 SHALL have parameter num_events_p, default 7, giving the number of per-tile stall/event inputs.
REQ-002 SHALL have parameter counter_width_p, default 32, giving the width of every counter.
REQ-003 SHALL have parameter x_cord_width_p, default 2, giving the tile X id width.
REQ-004 SHALL have parameter y_cord_width_p, default 3, giving the tile Y id width.
REQ-005 SHALL define idx_width_lp = clog2(num_events_p+1), minimum 1.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n_i, input, 1, reset; it is asynchronous and active-low.
REQ-008 SHALL have port start_i, input, 1, start pulse (tile unfreeze edge); clears the counters and begins counting.
REQ-009 SHALL have port finish_i, input, 1, end-of-run indication; stops counting and starts readout.
REQ-010 SHALL have port events_i, input, num_events_p, per-cycle event flags (dmem, dx, bt, in_fifo, out_fifo, credit, res_acq stall).
REQ-011 SHALL have port x_id_i, input, x_cord_width_p, tile X id, passed to the output.
REQ-012 SHALL have port y_id_i, input, y_cord_width_p, tile Y id, passed to the output.
REQ-013 SHALL have port v_o, output, 1, readout word valid.
REQ-014 SHALL have port ready_i, input, 1, consumer ready.
REQ-015 SHALL have port idx_o, output, idx_width_lp, readout index: 0..num_events_p-1 are event counters; num_events_p is the cycle counter.
REQ-016 SHALL have port data_o, output, counter_width_p, counter value at idx_o.
REQ-017 SHALL have port x_o and y_o, outputs, coordinate widths, registered copies of x_id_i and y_id_i, captured on start_i.
REQ-018 SHALL have port overflow_o, output, 1, sticky flag set when any counter has saturated.
REQ-019 SHALL have port done_o, output, 1, high when readout is complete.

Function
REQ-020 SHALL implement the FSM states IDLE, COUNT, DRAIN, DONE.
REQ-021 In IDLE or DONE, start_i SHALL zero all num_events_p+1 counters, clear overflow_o, capture x_o/y_o, and go to COUNT on the next edge.
REQ-022 In COUNT, the cycle counter SHALL increment by 1 every cycle in which start_i and finish_i are both low.
REQ-023 In COUNT, counter k SHALL increment by 1 in every cycle in which events_i[k]=1 and start_i and finish_i are both low.
REQ-024 Counters SHALL saturate at all-ones, never wrap; reaching saturation SHALL set overflow_o, which stays set until the next accepted start_i.
REQ-025 In COUNT, start_i SHALL zero all counters and stay in COUNT; counting resumes the following cycle.
REQ-026 In COUNT, start_i and finish_i high together SHALL be handled as start: start_i wins and finish_i is ignored.
REQ-027 In COUNT, finish_i alone SHALL freeze all counters (the finish cycle is not counted), set the read pointer to 0, and go to DRAIN.
REQ-028 In DRAIN, v_o=1, idx_o=pointer, and data_o=counter[pointer], all driven from registers.
REQ-029 In DRAIN, v_o SHALL NOT drop, and idx_o/data_o SHALL NOT change, until v_o&ready_i.
REQ-030 In DRAIN, on v_o&ready_i the pointer SHALL increment; the transfer at pointer=num_events_p SHALL go to DONE.
REQ-031 A readout SHALL be exactly num_events_p+1 transfers, in index order; maximum throughput is one word per cycle.
REQ-032 In DRAIN, start_i and finish_i SHALL be ignored.
REQ-033 In IDLE, finish_i SHALL be ignored. In DONE, finish_i SHALL be ignored.
REQ-034 done_o SHALL be 1 only in DONE.
REQ-035 v_o SHALL be 0 in every state other than DRAIN.

Reset
REQ-036 While reset_n_i=0, the block SHALL immediately force: state IDLE, all counters 0, pointer 0, v_o=0, done_o=0, overflow_o=0, idx_o=0, data_o=0, x_o=0, y_o=0.
REQ-037 Reset asserted mid-COUNT or mid-DRAIN SHALL abandon the run; no partial readout after deassertion.
REQ-038 After reset deasserts, the block SHALL stay in IDLE until start_i.

Verification
REQ-039 Basic run: start_i pulse, 10 cycles with events_i[0]=1 on 4 of them, then finish_i -> 8 transfers; idx0=4, idx1..6=0, idx7=10; done_o=1 afterwards.
REQ-040 Backpressure: ready_i=0 for 5 cycles during DRAIN -> v_o, idx_o, data_o held stable; all 8 words still delivered, in order, without loss.
REQ-041 Restart collision: start_i and finish_i together in COUNT -> counters zeroed, state stays COUNT, v_o stays 0.
REQ-042 Saturation: counter_width_p=4, 20 counting cycles -> cycle counter reads 15, overflow_o=1; overflow_o clears on the next start_i.
REQ-043 Reset mid-DRAIN: reset_n_i low while idx_o=3 -> v_o=0 at once; after release the block stays IDLE; finish_i has no effect.
REQ-044 Rerun: start_i in DONE with new x_id_i/y_id_i -> x_o/y_o updated, counters zero, second run counts correctly.
